// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM line period/high-time capture with duty quantisation and stuck detection
// Optional glitch filter: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W      = 18,
    parameter int TIMEOUT    = 200000,
    parameter int FILTER_LEN = 4
) (
    input  logic             clock_50mhz,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [1:0]       duty_code,
    output logic             meas_valid,
    output logic             locked,
    output logic             stuck
);

    typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    state_t state, state_next;
    logic sync1, sync2, s, s_d;
    logic rise, fall, timeout;
    logic do_meas, enter_stuck, clr_cnt;
    logic [CNT_W-1:0] pcnt, hcnt;
    logic [CNT_W+2:0] h8, pe, p3, p5, p7;
    logic [1:0] quant;

    always_ff @(posedge clock_50mhz) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            s_d   <= s;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] filt_cnt;
    logic          s_filt;

    always_ff @(posedge clock_50mhz) begin
        if (!reset_n) begin
            filt_cnt <= '0;
            s_filt   <= 1'b0;
        end else if (sync2 == s_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            s_filt   <= sync2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign s = s_filt;
`else
    if (FILTER_LEN < 1) begin : g_filter_len_invalid
    end

    assign s = sync2;
`endif

    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign timeout = (pcnt == TO);

    // Products are CNT_W+3 bits wide so 8*h and 7*p cannot overflow.
    assign h8 = {hcnt, 3'b000};
    assign pe = {3'b000, pcnt};
    assign p3 = pe + (pe << 1);
    assign p5 = pe + (pe << 2);
    assign p7 = (pe << 3) - pe;

    always_comb begin
        quant = 2'd3;
        if (h8 < p3)      quant = 2'd0;
        else if (h8 < p5) quant = 2'd1;
        else if (h8 < p7) quant = 2'd2;
    end

    always_comb begin
        state_next  = state;
        do_meas     = 1'b0;
        enter_stuck = 1'b0;
        clr_cnt     = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MEAS;
                end else if (timeout) begin
                    state_next  = STUCK;
                    enter_stuck = 1'b1;
                end
            end
            MEAS: begin
                if (rise) begin
                    do_meas = 1'b1;
                end else if (timeout) begin
                    state_next  = STUCK;
                    enter_stuck = 1'b1;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_next = MEAS;
                end else if (fall) begin
                    // Restart the timeout so IDLE gets a full window before re-declaring stuck.
                    state_next = IDLE;
                    clr_cnt    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_50mhz) begin
        if (!reset_n) begin
            state <= IDLE;
            pcnt  <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_next;
            if (rise) begin
                pcnt <= CNT_W'(1);
                hcnt <= CNT_W'(1);
            end else if (clr_cnt) begin
                pcnt <= '0;
                hcnt <= '0;
            end else begin
                if (pcnt != TO)      pcnt <= pcnt + CNT_W'(1);
                if (s && hcnt != TO) hcnt <= hcnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_50mhz) begin
        if (!reset_n) begin
            period     <= '0;
            high_time  <= '0;
            duty_code  <= 2'd0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (do_meas) begin
                period     <= pcnt;
                high_time  <= hcnt;
                duty_code  <= quant;
                meas_valid <= 1'b1;
                locked     <= 1'b1;
            end
            if (enter_stuck) begin
                period     <= '0;
                high_time  <= '0;
                duty_code  <= s ? 2'd3 : 2'd0;
                meas_valid <= 1'b1;
                locked     <= 1'b0;
                stuck      <= 1'b1;
            end
            if (state == STUCK && state_next != STUCK) stuck <= 1'b0;
        end
    end

endmodule
